// File: rtl/sr_pulse_sequencer_pkg.sv
// Shared types and default widths for the SR flip-flop pulse sequencer.
// Optional feedback checking is enabled by defining SR_SEQ_FB_CHECK_EN.
package sr_seq_pkg;

    localparam int SR_SEQ_CNT_W = 8;
    localparam int SR_SEQ_REP_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SET    = 3'd1,
        ST_HOLD_H = 3'd2,
        ST_RST    = 3'd3,
        ST_HOLD_L = 3'd4
    } sr_seq_state_e;

endpackage

// File: rtl/sr_pulse_sequencer_if.sv
// Control/status bundle between host, sequencer and the SR flip-flop.
// The slave modport is the sequencer side; master is the host/flop side.
interface sr_pulse_sequencer_if
    import sr_seq_pkg::*;
#(
    parameter int CNT_W = SR_SEQ_CNT_W,
    parameter int REP_W = SR_SEQ_REP_W
);
    logic             start;
    logic             stop;
    logic [CNT_W-1:0] high_len;
    logic [CNT_W-1:0] low_len;
    logic [REP_W-1:0] repeat_cnt;
    logic             q;
    logic             s;
    logic             r;
    logic             busy;
    logic             done;
    logic             err;

    modport slave (
        input  start, stop, high_len, low_len, repeat_cnt, q,
        output s, r, busy, done, err
    );

    modport master (
        output start, stop, high_len, low_len, repeat_cnt, q,
        input  s, r, busy, done, err
    );

endinterface

// File: rtl/sr_pulse_sequencer_timer.sv
// Loadable saturating down-counter shared by the HOLD_H and HOLD_L phases.
// expired_o marks the last cycle of a hold (count at 1 or below).
module sr_seq_timer
    import sr_seq_pkg::*;
#(
    parameter int CNT_W = SR_SEQ_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic [CNT_W-1:0] value_o,
    output logic             expired_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign value_o   = cnt_q;
    assign expired_o = (cnt_q <= CNT_W'(1));

endmodule

// File: rtl/sr_pulse_sequencer.sv
// Drives exclusive one-cycle set/reset pulses into an SR flip-flop.
// Define SR_SEQ_FB_CHECK_EN to compare flop feedback q against the sequence.
module sr_pulse_sequencer
    import sr_seq_pkg::*;
#(
    parameter int CNT_W = SR_SEQ_CNT_W,
    parameter int REP_W = SR_SEQ_REP_W
) (
    input  logic                clk,
    input  logic                reset,
    sr_pulse_sequencer_if.slave bus
);

    localparam logic [2:0] S_IDLE   = 3'(ST_IDLE);
    localparam logic [2:0] S_SET    = 3'(ST_SET);
    localparam logic [2:0] S_HOLD_H = 3'(ST_HOLD_H);
    localparam logic [2:0] S_RST    = 3'(ST_RST);
    localparam logic [2:0] S_HOLD_L = 3'(ST_HOLD_L);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] hi_q, hi_d;
    logic [CNT_W-1:0] lo_q, lo_d;
    logic [REP_W-1:0] rem_q, rem_d;
    logic             inf_q, inf_d;
    logic             abort_q, abort_d;
    logic             s_q, s_d;
    logic             r_q, r_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic             accept;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_exp;
    logic [CNT_W-1:0] unused_tmr_value;

    assign accept   = (state_q == S_IDLE) && bus.start && !bus.stop;
    assign tmr_load = (state_q == S_SET) || (state_q == S_RST);
    assign tmr_val  = (state_q == S_SET) ? hi_q : lo_q;

    sr_seq_timer #(.CNT_W(CNT_W)) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .value_o    (unused_tmr_value),
        .expired_o  (tmr_exp)
    );

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        rem_d   = rem_q;
        inf_d   = inf_q;
        abort_d = abort_q;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_SET;
                    hi_d    = (bus.high_len == '0) ? CNT_W'(1) : bus.high_len;
                    lo_d    = (bus.low_len == '0) ? CNT_W'(1) : bus.low_len;
                    rem_d   = bus.repeat_cnt;
                    inf_d   = (bus.repeat_cnt == '0);
                    abort_d = 1'b0;
                end
            end
            S_SET: begin
                state_d = bus.stop ? S_RST : S_HOLD_H;
                abort_d = bus.stop;
            end
            S_HOLD_H: begin
                if (bus.stop) begin
                    state_d = S_RST;
                    abort_d = 1'b1;
                end else if (tmr_exp) begin
                    state_d = S_RST;
                end
            end
            S_RST: begin
                if (bus.stop || abort_q) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_HOLD_L;
                end
            end
            S_HOLD_L: begin
                if (bus.stop) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else if (tmr_exp) begin
                    // A zero repeat count means free-running: never count down.
                    if (!inf_q && rem_q != '0) begin
                        rem_d = rem_q - REP_W'(1);
                    end
                    if (!inf_q && rem_q <= REP_W'(1)) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_SET;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign s_d = (state_d == S_SET);
    assign r_d = (state_d == S_RST);

`ifdef SR_SEQ_FB_CHECK_EN
    logic fb_bad;

    // q lags s/r by one edge: still 1 while leaving RST, 0 once HOLD_L ends.
    always_comb begin
        fb_bad = 1'b0;
        if (state_q == S_RST && !bus.q) begin
            fb_bad = 1'b1;
        end
        if (state_q == S_HOLD_L && state_d != S_HOLD_L && bus.q) begin
            fb_bad = 1'b1;
        end
        err_d = accept ? 1'b0 : (err_q | fb_bad);
    end
`else
    logic unused_q;

    assign unused_q = bus.q;
    assign err_d    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            rem_q   <= '0;
            inf_q   <= 1'b0;
            abort_q <= 1'b0;
            s_q     <= 1'b0;
            r_q     <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            rem_q   <= rem_d;
            inf_q   <= inf_d;
            abort_q <= abort_d;
            s_q     <= s_d;
            r_q     <= r_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bus.s    = s_q;
    assign bus.r    = r_q;
    assign bus.busy = (state_q != S_IDLE);
    assign bus.done = done_q;
    assign bus.err  = err_q;

endmodule

// File: tb/tb_sr_pulse_sequencer.sv
// Directed bench for sr_pulse_sequencer with a behavioural SR flip-flop.
// Build with SR_SEQ_FB_CHECK_EN to exercise the feedback error path.
module tb_sr_pulse_sequencer;

    logic clk;
    logic reset;
    logic q_ff;
    logic force_low;
    int   checks;
    int   errors;

    logic s_tr    [0:31];
    logic r_tr    [0:31];
    logic done_tr [0:31];
    logic busy_tr [0:31];
    logic err_tr  [0:31];

    sr_pulse_sequencer_if #(.CNT_W(8), .REP_W(8)) bus ();

    sr_pulse_sequencer #(.CNT_W(8), .REP_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset) q_ff <= 1'b0;
        else if (bus.s) q_ff <= 1'b1;
        else if (bus.r) q_ff <= 1'b0;
    end

    assign bus.q = force_low ? 1'b0 : q_ff;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one edge; returns at cycle 0 (first SET cycle).
    task automatic go(input logic [7:0] hi, input logic [7:0] lo,
                      input logic [7:0] rep);
        bus.high_len   = hi;
        bus.low_len    = lo;
        bus.repeat_cnt = rep;
        bus.start      = 1'b1;
        tick();
        bus.start      = 1'b0;
    endtask

    task automatic capture(input int n);
        for (int i = 0; i < n; i++) begin
            s_tr[i]    = bus.s;
            r_tr[i]    = bus.r;
            done_tr[i] = bus.done;
            busy_tr[i] = bus.busy;
            err_tr[i]  = bus.err;
            tick();
        end
    endtask

    task automatic test_reset();
        logic [4:0] got;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        got = {bus.s, bus.r, bus.busy, bus.done, bus.err};
        checks++;
        if (got !== 5'b0) begin
            errors++;
            $display("FAIL reset_outs got %b exp 00000", got);
        end
    endtask

    task automatic test_basic();
        logic [3:0] got, exp;
        go(8'd3, 8'd2, 8'd2);
        capture(16);
        for (int c = 0; c < 16; c++) begin
            exp = {c == 0 || c == 7, c == 4 || c == 11,
                   c == 14, c < 14};
            got = {s_tr[c], r_tr[c], done_tr[c], busy_tr[c]};
            checks++;
            if (got !== exp || (s_tr[c] && r_tr[c])) begin
                errors++;
                $display("FAIL basic c=%0d srdb got %b exp %b",
                         c, got, exp);
            end
        end
    endtask

    task automatic test_zero_len();
        logic [3:0] got, exp;
        go(8'd0, 8'd0, 8'd1);
        capture(6);
        for (int c = 0; c < 6; c++) begin
            exp = {c == 0, c == 2, c == 4, c < 4};
            got = {s_tr[c], r_tr[c], done_tr[c], busy_tr[c]};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL zero_len c=%0d srdb got %b exp %b",
                         c, got, exp);
            end
        end
    endtask

    task automatic test_abort();
        logic [3:0] got;
        go(8'd5, 8'd2, 8'd0);
        tick();
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        got = {bus.s, bus.r, bus.done, bus.busy};
        checks++;
        if (got !== 4'b0101) begin
            errors++;
            $display("FAIL abort_rst srdb got %b exp 0101", got);
        end
        tick();
        got = {bus.s, bus.r, bus.done, bus.busy};
        checks++;
        if (got !== 4'b0010) begin
            errors++;
            $display("FAIL abort_done srdb got %b exp 0010", got);
        end
        tick();
        checks++;
        if (bus.q !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle q/done got %b%b exp 00",
                     bus.q, bus.done);
        end
    endtask

    task automatic test_ignored();
        logic [3:0] got, exp;
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.s !== 1'b0) begin
            errors++;
            $display("FAIL start_stop busy/s got %b%b exp 00",
                     bus.busy, bus.s);
        end
        go(8'd2, 8'd1, 8'd1);
        tick();
        bus.high_len   = 8'd7;
        bus.low_len    = 8'd7;
        bus.repeat_cnt = 8'd0;
        bus.start      = 1'b1;
        tick();
        bus.start      = 1'b0;
        capture(5);
        for (int i = 0; i < 5; i++) begin
            exp = {1'b0, i == 1, i == 3, i < 3};
            got = {s_tr[i], r_tr[i], done_tr[i], busy_tr[i]};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL busy_start c=%0d srdb got %b exp %b",
                         i + 2, got, exp);
            end
        end
    endtask

    task automatic test_reset_midrun();
        logic [4:0] got5;
        logic [3:0] got, exp;
        go(8'd4, 8'd1, 8'd0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        got5 = {bus.s, bus.r, bus.busy, bus.done, bus.err};
        checks++;
        if (got5 !== 5'b0) begin
            errors++;
            $display("FAIL reset_mid outs got %b exp 00000", got5);
        end
        tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.r !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid idle busy/r got %b%b exp 00",
                     bus.busy, bus.r);
        end
        go(8'd1, 8'd1, 8'd1);
        capture(6);
        for (int c = 0; c < 6; c++) begin
            exp = {c == 0, c == 2, c == 4, c < 4};
            got = {s_tr[c], r_tr[c], done_tr[c], busy_tr[c]};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL restart c=%0d srdb got %b exp %b",
                         c, got, exp);
            end
        end
    endtask

    task automatic test_feedback();
        logic exp;
        go(8'd2, 8'd1, 8'd1);
        force_low = 1'b1;
        capture(8);
        force_low = 1'b0;
        for (int c = 0; c < 8; c++) begin
`ifdef SR_SEQ_FB_CHECK_EN
            exp = (c >= 4);
`else
            exp = 1'b0;
`endif
            checks++;
            if (err_tr[c] !== exp) begin
                errors++;
                $display("FAIL fb_err c=%0d got %b exp %b",
                         c, err_tr[c], exp);
            end
        end
        checks++;
        if (done_tr[5] !== 1'b1) begin
            errors++;
            $display("FAIL fb_done got %b exp 1", done_tr[5]);
        end
        go(8'd1, 8'd1, 8'd1);
        checks++;
        if (bus.err !== 1'b0 || bus.s !== 1'b1) begin
            errors++;
            $display("FAIL fb_clear err/s got %b%b exp 01",
                     bus.err, bus.s);
        end
        capture(6);
        checks++;
        if (err_tr[5] !== 1'b0) begin
            errors++;
            $display("FAIL fb_good got %b exp 0", err_tr[5]);
        end
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        force_low      = 1'b0;
        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.stop       = 1'b0;
        bus.high_len   = '0;
        bus.low_len    = '0;
        bus.repeat_cnt = '0;
        test_reset();
        test_basic();
        test_zero_len();
        test_abort();
        test_ignored();
        test_reset_midrun();
        test_feedback();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
